// File: rtl/lsu_pkg.sv
// Purpose : shared types and helpers for the RV32I load/store unit.
// Latency : n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: funct3_t (RV32I width/extension codes), lsu_state_t (unit FSM),
//           is_misaligned() and is_illegal_funct3() request checks.
package lsu_pkg;

    // RV32I load/store funct3 codes. 011/110/111 are not memory ops.
    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_RMW_MERGE = 2'd2,
        ST_RESP      = 2'd3
    } lsu_state_t;

    // Halfwords need an even address, words a 4-byte aligned one; bytes never misalign.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (f3)
            F3_H, F3_HU: mis = addr_lo[0];
            F3_W:        mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Unsigned variants only make sense for loads; 011/110/111 are never legal.
    function automatic logic is_illegal_funct3(input logic [2:0] f3, input logic is_store);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: bad = 1'b0;
            F3_BU, F3_HU:     bad = is_store;
            default:          bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Purpose : lane steering for the load/store unit - load lane extract with sign/zero
//           extension, and sub-word store merge into a freshly read memory word.
// Latency : combinational. Backpressure: none (pure function of its inputs).
// Ports   : rd_word (word read from memory), lane (byte address [1:0]), funct3 (access code),
//           wdata (low 16 bits of store data), load_data (extended load result),
//           merge_data (rd_word with the store lane(s) replaced).
module lsu_align (
    input  logic [31:0] rd_word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);
    import lsu_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rd_word[7:0];
        case (lane)
            2'd0:    byte_sel = rd_word[7:0];
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        // lane[0] is zero for any halfword that passed the alignment check
        half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
    end

    always_comb begin
        load_data = rd_word;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        merge_data = rd_word;
        if (funct3 == F3_B) begin
            case (lane)
                2'd0:    merge_data[7:0]   = wdata[7:0];
                2'd1:    merge_data[15:8]  = wdata[7:0];
                2'd2:    merge_data[23:16] = wdata[7:0];
                default: merge_data[31:24] = wdata[7:0];
            endcase
        end else if (funct3 == F3_H) begin
            if (lane[1]) begin
                merge_data[31:16] = wdata;
            end else begin
                merge_data[15:0] = wdata;
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Purpose : RV32I load/store initiator onto a word-wide, registered-read data memory.
// Latency : accept->resp_valid 1 cycle for SW and rejected requests, 2 cycles for loads and SB/SH.
// Backpressure: req_ready only in IDLE; response held in RESP until resp_ready, one request in flight.
// Ports   : req_* (execute-stage request, valid/ready), resp_* (response, valid/ready),
//           mem_* (word port: address with [1:0]=0, write data/enable, read data one cycle later).
module load_store_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEMORY_SIZE   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    output logic                     mem_write_enable,
    input  logic [DATA_WIDTH-1:0]    mem_read_data
);
    import lsu_pkg::*;

    // Request latch. Direction is implied by the state path taken after accept,
    // and only the low halfword of store data is needed past the accept cycle
    // (SW writes straight from the request bus).
    lsu_state_t               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]               funct3_q, funct3_d;
    logic [15:0]              wdata_q, wdata_d;

    // Response registers
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic                     err_q, err_d;

    logic                     accept;
    logic                     out_of_range;
    logic                     req_err;
    logic [DATA_WIDTH-1:0]    load_data;
    logic [DATA_WIDTH-1:0]    merge_data;

    // Gate with rst_n so nothing is accepted while reset is held.
    assign req_ready = rst_n && (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;

    assign out_of_range = |req_addr[ADDRESS_WIDTH-1:MEMORY_SIZE+2];
    assign req_err      = out_of_range
                       || is_misaligned(req_funct3, req_addr[1:0])
                       || is_illegal_funct3(req_funct3, req_write);

    // Both the load and the RMW path work on the word returned for the latched address.
    lsu_align u_align (
        .rd_word    (mem_read_data),
        .lane       (addr_q[1:0]),
        .funct3     (funct3_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        // Idle/waiting cycles still drive the port from the latch; only the
        // write enable carries meaning there, and it stays low.
        mem_address      = {addr_q[ADDRESS_WIDTH-1:2], 2'b00};
        mem_write_data   = merge_data;
        mem_write_enable = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d   = req_addr;
                    funct3_d = req_funct3;
                    wdata_d  = req_wdata[15:0];
                    rdata_d  = '0;
                    err_d    = req_err;
                    if (req_err) begin
                        // Rejected requests never reach memory.
                        state_d = ST_RESP;
                    end else begin
                        // Present the address this cycle so read data lands next cycle.
                        mem_address = {req_addr[ADDRESS_WIDTH-1:2], 2'b00};
                        if (!req_write) begin
                            state_d = ST_LOAD_WAIT;
                        end else if (req_funct3 == F3_W) begin
                            mem_write_data   = req_wdata;
                            mem_write_enable = 1'b1;
                            state_d          = ST_RESP;
                        end else begin
                            // Sub-word store: read the word now, merge and write back next cycle.
                            state_d = ST_RMW_MERGE;
                        end
                    end
                end
            end

            ST_LOAD_WAIT: begin
                rdata_d = load_data;
                state_d = ST_RESP;
            end

            ST_RMW_MERGE: begin
                mem_write_enable = 1'b1;
                state_d          = ST_RESP;
            end

            ST_RESP: begin
                // Return to IDLE only; the next request is accepted one cycle later.
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Purpose : self-checking bench for load_store_unit paired with a registered-read word memory.
// Latency : n/a. Backpressure: bench drives resp_ready and can hold it low for a number of cycles.
// Structure: transaction-level reference memory plus response queue, one negedge compare
//            process, and directed requests with hand-computed literal results.
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam int MS = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (32),
        .MEMORY_SIZE   (MS)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_rdata       (resp_rdata),
        .resp_err         (resp_err),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    // Word memory: registered read, read-before-write, cleared on the first clock edge.
    logic [31:0] mem [0:65535];
    logic        mem_cleared = 1'b0;
    logic [15:0] mem_idx;
    assign mem_idx = mem_address[17:2];

    always @(posedge clk) begin
        if (!mem_cleared) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 32'h0;
            mem_cleared   <= 1'b1;
            mem_read_data <= 32'h0;
        end else begin
            mem_read_data <= mem[mem_idx];
            if (mem_write_enable) mem[mem_idx] <= mem_write_data;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [int unsigned];

    typedef struct packed {
        logic [31:0] rd;
        logic        er;
    } exp_t;
    exp_t exp_q[$];
    logic err_txn = 1'b0;

    function automatic logic [31:0] ref_rd(input int unsigned w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    task automatic model_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int unsigned size;
        int unsigned w;
        int unsigned sh;
        logic [31:0] word;
        logic [31:0] mask;
        logic [31:0] v;
        er = 1'b0;
        rd = 32'h0;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default: begin size = 1; er = 1'b1; end
        endcase
        if (wr && f3[2]) er = 1'b1;
        if ((addr % size) != 0) er = 1'b1;
        if (addr >= (32'h1 << (MS + 2))) er = 1'b1;
        if (er) return;
        w    = addr >> 2;
        sh   = 8 * (addr % 4);
        word = ref_rd(w);
        if (wr) begin
            mask = (size == 4) ? 32'hFFFF_FFFF : (((32'h1 << (8 * size)) - 1) << sh);
            ref_mem[w] = (word & ~mask) | ((wd << sh) & mask);
        end else begin
            v = word >> sh;
            if (size == 1)      rd = f3[2] ? (v & 32'hFF)   : {{24{v[7]}}, v[7:0]};
            else if (size == 2) rd = f3[2] ? (v & 32'hFFFF) : {{16{v[15]}}, v[15:0]};
            else                rd = word;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_txn) check("err_no_mem_write", {31'h0, mem_write_enable}, 32'h0);
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp_valid", {31'h0, resp_valid}, 32'h0);
                end else begin
                    check("resp_rdata", resp_rdata, exp_q[0].rd);
                    check("resp_err", {31'h0, resp_err}, {31'h0, exp_q[0].er});
                    check("req_ready_in_resp", {31'h0, req_ready}, 32'h0);
                    check("mem_we_in_resp", {31'h0, mem_write_enable}, 32'h0);
                    if (resp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Called aligned to posedge+1; returns aligned to posedge+1 after the response handshake.
    task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int stall,
                           output logic [31:0] rd, output logic er, output int lat);
        exp_t e;
        logic [31:0] mrd;
        logic        mer;
        model_req(wr, f3, addr, wd, mrd, mer);
        e.rd = mrd;
        e.er = mer;
        rd   = 32'h0;
        er   = 1'b0;
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        check("req_ready_idle", {31'h0, req_ready}, 32'h1);
        exp_q.push_back(e);
        err_txn = mer;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!resp_valid) begin
            check("resp_valid_timeout", {31'h0, resp_valid}, 32'h1);
            exp_q.delete();
            err_txn = 1'b0;
            return;
        end
        rd = resp_rdata;
        er = resp_err;
        repeat (stall) begin
            @(posedge clk);
            #1;
        end
        if (stall > 0) check("resp_valid_held", {31'h0, resp_valid}, 32'h1);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        err_txn    = 1'b0;
    endtask

    task automatic txn(input string name, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input int stall,
                       input logic [31:0] exp_rd, input logic exp_er, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lat;
        run_req(wr, f3, addr, wd, stall, rd, er, lat);
        check({name, "_rdata"}, rd, exp_rd);
        check({name, "_err"}, {31'h0, er}, {31'h0, exp_er});
        check({name, "_latency"}, lat, exp_lat);
        if (addr < 32'h0004_0000) check({name, "_memword"}, mem[addr[17:2]], ref_rd(addr >> 2));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #2;
        check("rst_req_ready", {31'h0, req_ready}, 32'h0);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_err", {31'h0, resp_err}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_we", {31'h0, mem_write_enable}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_req_ready", {31'h0, req_ready}, 32'h1);

        // Word store/load and lane extraction
        txn("sw_10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0,        1'b0, 1);
        txn("lw_10",  1'b0, 3'b010, 32'h10, 32'h0,        0, 32'hDEADBEEF, 1'b0, 2);
        txn("lb_13",  1'b0, 3'b000, 32'h13, 32'h0,        0, 32'hFFFFFFDE, 1'b0, 2);
        txn("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0,        0, 32'h000000DE, 1'b0, 2);
        txn("lh_12",  1'b0, 3'b001, 32'h12, 32'h0,        0, 32'hFFFFDEAD, 1'b0, 2);
        txn("lhu_10", 1'b0, 3'b101, 32'h10, 32'h0,        0, 32'h0000BEEF, 1'b0, 2);

        // Read-modify-write sub-word stores
        txn("sb_11",  1'b1, 3'b000, 32'h11, 32'h00000055, 0, 32'h0,        1'b0, 2);
        txn("lw_sb",  1'b0, 3'b010, 32'h10, 32'h0,        0, 32'hDEAD55EF, 1'b0, 2);
        txn("sh_12",  1'b1, 3'b001, 32'h12, 32'h00001234, 0, 32'h0,        1'b0, 2);
        txn("lw_sh",  1'b0, 3'b010, 32'h10, 32'h0,        0, 32'h123455EF, 1'b0, 2);

        // Rejected requests
        txn("err_lw_02",    1'b0, 3'b010, 32'h02,        32'h0,        0, 32'h0, 1'b1, 1);
        txn("err_sh_01",    1'b1, 3'b001, 32'h01,        32'h0000FFFF, 0, 32'h0, 1'b1, 1);
        txn("err_lw_range", 1'b0, 3'b010, 32'h0004_0000, 32'h0,        0, 32'h0, 1'b1, 1);
        txn("err_f3_011",   1'b0, 3'b011, 32'h10,        32'h0,        0, 32'h0, 1'b1, 1);
        txn("err_sbu",      1'b1, 3'b100, 32'h10,        32'h000000AA, 0, 32'h0, 1'b1, 1);
        txn("lw_unchanged", 1'b0, 3'b010, 32'h10,        32'h0,        0, 32'h123455EF, 1'b0, 2);
        txn("lw_00",        1'b0, 3'b010, 32'h00,        32'h0,        0, 32'h0, 1'b0, 2);

        // Response held under backpressure
        txn("lw_stall", 1'b0, 3'b010, 32'h10, 32'h0, 5, 32'h123455EF, 1'b0, 2);

        // Every byte lane and both halfword lanes of a second word
        txn("sb_20",   1'b1, 3'b000, 32'h20, 32'h00000081, 0, 32'h0,        1'b0, 2);
        txn("sb_21",   1'b1, 3'b000, 32'h21, 32'h00000002, 0, 32'h0,        1'b0, 2);
        txn("sb_22",   1'b1, 3'b000, 32'h22, 32'h000000F3, 0, 32'h0,        1'b0, 2);
        txn("sb_23",   1'b1, 3'b000, 32'h23, 32'h00000004, 0, 32'h0,        1'b0, 2);
        txn("lw_20",   1'b0, 3'b010, 32'h20, 32'h0,        0, 32'h04F30281, 1'b0, 2);
        txn("lb_20",   1'b0, 3'b000, 32'h20, 32'h0,        0, 32'hFFFFFF81, 1'b0, 2);
        txn("lb_22",   1'b0, 3'b000, 32'h22, 32'h0,        0, 32'hFFFFFFF3, 1'b0, 2);
        txn("lh_22",   1'b0, 3'b001, 32'h22, 32'h0,        0, 32'h000004F3, 1'b0, 2);
        txn("sh_20",   1'b1, 3'b001, 32'h20, 32'hFFFF8000, 0, 32'h0,        1'b0, 2);
        txn("lh_20",   1'b0, 3'b001, 32'h20, 32'h0,        0, 32'hFFFF8000, 1'b0, 2);
        txn("lhu_20",  1'b0, 3'b101, 32'h20, 32'h0,        0, 32'h00008000, 1'b0, 2);

        // Highest legal word
        txn("sw_top", 1'b1, 3'b010, 32'h0003_FFFC, 32'hCAFEF00D, 0, 32'h0,        1'b0, 1);
        txn("lw_top", 1'b0, 3'b010, 32'h0003_FFFC, 32'h0,        0, 32'hCAFEF00D, 1'b0, 2);

        // Reset while an SB is between read and merge: memory must stay untouched
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h10;
        req_wdata  = 32'h000000AA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst_rmw_mem_we", {31'h0, mem_write_enable}, 32'h0);
        check("rst_rmw_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_rmw_req_ready", {31'h0, req_ready}, 32'h0);
        @(posedge clk);
        #1;
        check("rst_rmw_word", mem[16'h0004], 32'h123455EF);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_rmw_idle", {31'h0, req_ready}, 32'h1);
        txn("lw_after_rst", 1'b0, 3'b010, 32'h10, 32'h0, 0, 32'h123455EF, 1'b0, 2);

        check("exp_queue_drained", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
